// File: rtl/operand_fetch_unit_pkg.sv
// Shared definitions for the operand fetch stage: datapath sizes, opcodes, FSM states.
// Pure package with no logic, no latency and no flow control.
package operand_fetch_unit_pkg;

    localparam int DATA_WIDTH           = 32;
    localparam int DATA_INDEX_LIMIT     = DATA_WIDTH - 1;
    localparam int REG_ADDR_INDEX_LIMIT = 4;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JMP   = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_PUSH  = 6'h1b;
    localparam logic [5:0] OP_POP   = 6'h1c;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_CAP  = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        CLS_R = 2'd0,
        CLS_I = 2'd1,
        CLS_J = 2'd2
    } instr_class_t;

    function automatic instr_class_t classify(input logic [5:0] op);
        if (op == OP_RTYPE) return CLS_R;
        if (op == OP_JMP || op == OP_JAL || op == OP_PUSH || op == OP_POP) return CLS_J;
        return CLS_I;
    endfunction

endpackage

// File: rtl/instr_field_decoder.sv
// Splits an instruction into fields, class, extended immediate and destination register.
// Purely combinational: zero latency, no flow control.
module instr_field_decoder
    import operand_fetch_unit_pkg::*;
(
    input  logic [31:0]  instr,
    output logic [5:0]   opcode,
    output logic [4:0]   rs,
    output logic [4:0]   rt,
    output logic [4:0]   shamt,
    output logic [5:0]   funct,
    output instr_class_t cls,
    output logic [31:0]  ext_imm,
    output logic [4:0]   dest
);

    logic [4:0]  rd;
    logic [15:0] imm;
    logic [25:0] addr;

    assign opcode = instr[31:26];
    assign rs     = instr[25:21];
    assign rt     = instr[20:16];
    assign rd     = instr[15:11];
    assign shamt  = instr[10:6];
    assign funct  = instr[5:0];
    assign imm    = instr[15:0];
    assign addr   = instr[25:0];

    // For J-type the "immediate" is the zero-extended jump target, which becomes OP2.
    always_comb begin
        cls     = classify(opcode);
        ext_imm = {{16{imm[15]}}, imm};
        dest    = rt;
        case (cls)
            CLS_R: begin
                ext_imm = '0;
                dest    = rd;
            end
            CLS_J: begin
                ext_imm = {6'b0, addr};
                dest    = (opcode == OP_JAL) ? 5'd31 : 5'd0;
            end
            default: begin
                if (opcode == OP_ANDI || opcode == OP_ORI) ext_imm = {16'b0, imm};
            end
        endcase
    end

endmodule

// File: rtl/operand_fetch_unit.sv
// Decodes an instruction, reads its operands from the register file and owns the file's write port.
// R/I-type reach OUT 3 cycles after accept, J-type 1 cycle; OUT holds under backpressure, writebacks stall only in RD/CAP.
module operand_fetch_unit #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [31:0]               IN_INSTR,
    input  logic                      IN_VALID,
    output logic                      IN_READY,
    input  logic                      WB_VALID,
    output logic                      WB_READY,
    input  logic [REG_ADDR_WIDTH-1:0] WB_ADDR,
    input  logic [DATA_WIDTH-1:0]     WB_DATA,
    output logic                      READ,
    output logic                      WRITE,
    output logic [REG_ADDR_WIDTH-1:0] ADDR_R1,
    output logic [REG_ADDR_WIDTH-1:0] ADDR_R2,
    output logic [REG_ADDR_WIDTH-1:0] ADDR_W,
    output logic [DATA_WIDTH-1:0]     DATA_W,
    input  logic [DATA_WIDTH-1:0]     DATA_R1,
    input  logic [DATA_WIDTH-1:0]     DATA_R2,
    output logic                      OUT_VALID,
    input  logic                      OUT_READY,
    output logic [5:0]                OUT_OPCODE,
    output logic [5:0]                OUT_FUNCT,
    output logic [4:0]                OUT_SHAMT,
    output logic [DATA_WIDTH-1:0]     OUT_OP1,
    output logic [DATA_WIDTH-1:0]     OUT_OP2,
    output logic [REG_ADDR_WIDTH-1:0] OUT_DEST
);

    import operand_fetch_unit_pkg::*;

    state_t       state;
    logic [5:0]   dec_opcode;
    logic [5:0]   dec_funct;
    logic [4:0]   dec_rs;
    logic [4:0]   dec_rt;
    logic [4:0]   dec_shamt;
    logic [4:0]   dec_dest;
    instr_class_t dec_cls;
    logic [31:0]  dec_imm;

    logic [4:0]   rs_q;
    logic [4:0]   rt_q;
    logic         rtype_q;
    logic [31:0]  imm_q;
    logic         in_fire;
    logic         wb_fire;

    instr_field_decoder u_decoder (
        .instr   (IN_INSTR),
        .opcode  (dec_opcode),
        .rs      (dec_rs),
        .rt      (dec_rt),
        .shamt   (dec_shamt),
        .funct   (dec_funct),
        .cls     (dec_cls),
        .ext_imm (dec_imm),
        .dest    (dec_dest)
    );

    // Writeback has priority in IDLE; the register file cannot read and write in one cycle.
    assign IN_READY  = !RST && (state == ST_IDLE) && !WB_VALID;
    assign WB_READY  = !RST && ((state == ST_IDLE) || (state == ST_OUT));
    assign in_fire   = IN_VALID && IN_READY;
    assign wb_fire   = WB_VALID && WB_READY;

    assign WRITE     = wb_fire && (WB_ADDR != '0);
    assign ADDR_W    = WRITE ? WB_ADDR : '0;
    assign DATA_W    = WRITE ? WB_DATA : '0;

    assign READ      = (state == ST_RD);
    assign ADDR_R1   = READ ? rs_q : '0;
    assign ADDR_R2   = READ ? rt_q : '0;
    assign OUT_VALID = (state == ST_OUT);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= ST_IDLE;
            rs_q       <= '0;
            rt_q       <= '0;
            rtype_q    <= 1'b0;
            imm_q      <= '0;
            OUT_OPCODE <= '0;
            OUT_FUNCT  <= '0;
            OUT_SHAMT  <= '0;
            OUT_DEST   <= '0;
            OUT_OP1    <= '0;
            OUT_OP2    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_fire) begin
                        OUT_OPCODE <= dec_opcode;
                        OUT_FUNCT  <= dec_funct;
                        OUT_SHAMT  <= dec_shamt;
                        OUT_DEST   <= dec_dest;
                        rs_q       <= dec_rs;
                        rt_q       <= dec_rt;
                        rtype_q    <= (dec_cls == CLS_R);
                        imm_q      <= dec_imm;
                        if (dec_cls == CLS_J) begin
                            OUT_OP1 <= '0;
                            OUT_OP2 <= dec_imm;
                            state   <= ST_OUT;
                        end else begin
                            state   <= ST_RD;
                        end
                    end
                end
                ST_RD: state <= ST_CAP;
                ST_CAP: begin
                    // r0 reads as zero whatever the register file returns.
                    OUT_OP1 <= (rs_q == '0) ? '0 : DATA_R1;
                    OUT_OP2 <= rtype_q ? ((rt_q == '0) ? '0 : DATA_R2) : imm_q;
                    state   <= ST_OUT;
                end
                ST_OUT: begin
                    if (OUT_READY) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_operand_fetch_unit.sv
// Directed bench for operand_fetch_unit with a behavioural synchronous-read register file.
module tb_operand_fetch_unit;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [31:0] IN_INSTR = '0;
    logic        IN_VALID = 1'b0;
    logic        IN_READY;
    logic        WB_VALID = 1'b0;
    logic        WB_READY;
    logic [4:0]  WB_ADDR = '0;
    logic [31:0] WB_DATA = '0;
    logic        READ, WRITE;
    logic [4:0]  ADDR_R1, ADDR_R2, ADDR_W;
    logic [31:0] DATA_W;
    logic [31:0] DATA_R1 = '0;
    logic [31:0] DATA_R2 = '0;
    logic        OUT_VALID;
    logic        OUT_READY = 1'b1;
    logic [5:0]  OUT_OPCODE, OUT_FUNCT;
    logic [4:0]  OUT_SHAMT, OUT_DEST;
    logic [31:0] OUT_OP1, OUT_OP2;

    int total = 0;
    int passed = 0;
    int read_cnt = 0;
    int overlap = 0;
    int timeouts = 0;
    logic [31:0] rf [32];

    operand_fetch_unit dut (
        .CLK(CLK), .RST(RST),
        .IN_INSTR(IN_INSTR), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .WB_VALID(WB_VALID), .WB_READY(WB_READY), .WB_ADDR(WB_ADDR), .WB_DATA(WB_DATA),
        .READ(READ), .WRITE(WRITE), .ADDR_R1(ADDR_R1), .ADDR_R2(ADDR_R2),
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DATA_R1(DATA_R1), .DATA_R2(DATA_R2),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .OUT_OPCODE(OUT_OPCODE), .OUT_FUNCT(OUT_FUNCT), .OUT_SHAMT(OUT_SHAMT),
        .OUT_OP1(OUT_OP1), .OUT_OP2(OUT_OP2), .OUT_DEST(OUT_DEST)
    );

    always #5 CLK = ~CLK;

    // Register file model: synchronous read on READ, write on WRITE.
    always @(posedge CLK) begin
        if (READ && WRITE) overlap++;
        if (WRITE) rf[ADDR_W] = DATA_W;
        if (READ) begin
            read_cnt++;
            DATA_R1 <= rf[ADDR_R1];
            DATA_R2 <= rf[ADDR_R2];
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge CLK);
        #1;
    endtask

    task automatic send_instr(input logic [31:0] instr);
        IN_INSTR = instr;
        IN_VALID = 1'b1;
        #1;
        for (int i = 0; i < 20 && !IN_READY; i++) begin
            @(negedge CLK);
            #1;
        end
        if (!IN_READY) timeouts++;
        @(negedge CLK);
        IN_VALID = 1'b0;
        #1;
    endtask

    task automatic wb_write(input logic [4:0] a, input logic [31:0] d, output logic wrote);
        WB_ADDR  = a;
        WB_DATA  = d;
        WB_VALID = 1'b1;
        #1;
        for (int i = 0; i < 20 && !WB_READY; i++) begin
            @(negedge CLK);
            #1;
        end
        if (!WB_READY) timeouts++;
        wrote = WRITE;
        @(negedge CLK);
        WB_VALID = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        IN_VALID = 1'b1;
        IN_INSTR = 32'h00221820;
        repeat (2) @(negedge CLK);
        #1;
        total++; if (IN_READY !== 1'b0) $display("FAIL rst_in_ready got %h want 0", IN_READY); else passed++;
        total++; if (WB_READY !== 1'b0) $display("FAIL rst_wb_ready got %h want 0", WB_READY); else passed++;
        total++; if (OUT_VALID !== 1'b0) $display("FAIL rst_out_valid got %h want 0", OUT_VALID); else passed++;
        total++; if (READ !== 1'b0) $display("FAIL rst_read got %h want 0", READ); else passed++;
        total++; if ({OUT_OP1, OUT_OP2, OUT_DEST} !== '0) $display("FAIL rst_outputs got %h/%h/%h want 0", OUT_OP1, OUT_OP2, OUT_DEST); else passed++;
        IN_VALID = 1'b0;
        RST = 1'b0;
        #1;
        total++; if (IN_READY !== 1'b1) $display("FAIL idle_in_ready got %h want 1", IN_READY); else passed++;
        total++; if (WB_READY !== 1'b1) $display("FAIL idle_wb_ready got %h want 1", WB_READY); else passed++;
        total++; if (OUT_VALID !== 1'b0) $display("FAIL idle_out_valid got %h want 0", OUT_VALID); else passed++;
    endtask

    task automatic test_rtype;
        logic w1, w2;
        int rc;
        wb_write(5'd1, 32'h00000005, w1);
        wb_write(5'd2, 32'h0000000A, w2);
        total++; if ({w1, w2} !== 2'b11) $display("FAIL wb_write got %b want 11", {w1, w2}); else passed++;
        rc = read_cnt;
        send_instr(32'h00221820);
        total++; if ({READ, ADDR_R1, ADDR_R2} !== {1'b1, 5'd1, 5'd2}) $display("FAIL rd_cycle got %h/%0d/%0d want 1/1/2", READ, ADDR_R1, ADDR_R2); else passed++;
        wait_cycles(1);
        total++; if ({READ, OUT_VALID} !== 2'b00) $display("FAIL cap_cycle got %b want 00", {READ, OUT_VALID}); else passed++;
        wait_cycles(1);
        total++; if (OUT_VALID !== 1'b1) $display("FAIL r_latency got %h want 1", OUT_VALID); else passed++;
        total++; if (OUT_OP1 !== 32'h5) $display("FAIL r_op1 got %h want 00000005", OUT_OP1); else passed++;
        total++; if (OUT_OP2 !== 32'hA) $display("FAIL r_op2 got %h want 0000000a", OUT_OP2); else passed++;
        total++; if ({OUT_DEST, OUT_FUNCT} !== {5'd3, 6'h20}) $display("FAIL r_fields got %0d/%h want 3/20", OUT_DEST, OUT_FUNCT); else passed++;
        total++; if (read_cnt - rc !== 1) $display("FAIL r_read_cycles got %0d want 1", read_cnt - rc); else passed++;
        wait_cycles(1);
    endtask

    task automatic test_itype;
        logic w;
        wb_write(5'd1, 32'h00000007, w);
        total++; if (w !== 1'b1) $display("FAIL i_wb got %h want 1", w); else passed++;
        send_instr(32'h2022FFFF);
        wait_cycles(2);
        total++; if ({OUT_VALID, OUT_OP1} !== {1'b1, 32'h7}) $display("FAIL addi_op1 got %h/%h want 1/00000007", OUT_VALID, OUT_OP1); else passed++;
        total++; if (OUT_OP2 !== 32'hFFFFFFFF) $display("FAIL addi_sext got %h want ffffffff", OUT_OP2); else passed++;
        total++; if (OUT_DEST !== 5'd2) $display("FAIL addi_dest got %0d want 2", OUT_DEST); else passed++;
        wait_cycles(1);
        send_instr(32'h3422FFFF);
        wait_cycles(2);
        total++; if (OUT_OP2 !== 32'h0000FFFF) $display("FAIL ori_zext got %h want 0000ffff", OUT_OP2); else passed++;
        total++; if (OUT_OPCODE !== 6'h0d) $display("FAIL ori_opcode got %h want 0d", OUT_OPCODE); else passed++;
        wait_cycles(1);
    endtask

    task automatic test_jtype_r0;
        logic w;
        int rc;
        rc = read_cnt;
        send_instr(32'h0C000100);
        total++; if ({OUT_VALID, READ} !== 2'b10) $display("FAIL jal_latency got %b want 10", {OUT_VALID, READ}); else passed++;
        total++; if ({OUT_OP1, OUT_OP2} !== {32'h0, 32'h100}) $display("FAIL jal_ops got %h/%h want 0/00000100", OUT_OP1, OUT_OP2); else passed++;
        total++; if (OUT_DEST !== 5'd31) $display("FAIL jal_dest got %0d want 31", OUT_DEST); else passed++;
        wait_cycles(1);
        total++; if (read_cnt !== rc) $display("FAIL jal_no_read got %0d want %0d", read_cnt, rc); else passed++;
        wb_write(5'd0, 32'hDEADBEEF, w);
        total++; if (w !== 1'b0) $display("FAIL r0_write got %h want 0", w); else passed++;
        send_instr(32'h00002020);
        wait_cycles(2);
        total++; if ({OUT_OP1, OUT_OP2} !== 64'h0) $display("FAIL r0_read got %h/%h want 0/0", OUT_OP1, OUT_OP2); else passed++;
        wait_cycles(1);
    endtask

    task automatic test_conflict;
        IN_INSTR = 32'h00222820;
        IN_VALID = 1'b1;
        WB_ADDR  = 5'd6;
        WB_DATA  = 32'h00001234;
        WB_VALID = 1'b1;
        #1;
        total++; if ({WRITE, IN_READY, ADDR_W} !== {1'b1, 1'b0, 5'd6}) $display("FAIL conflict_wb got %h/%h/%0d want 1/0/6", WRITE, IN_READY, ADDR_W); else passed++;
        @(negedge CLK);
        WB_VALID = 1'b0;
        #1;
        total++; if (IN_READY !== 1'b1) $display("FAIL conflict_in_ready got %h want 1", IN_READY); else passed++;
        @(negedge CLK);
        IN_VALID = 1'b0;
        #1;
        total++; if ({READ, ADDR_R1} !== {1'b1, 5'd1}) $display("FAIL conflict_rd got %h/%0d want 1/1", READ, ADDR_R1); else passed++;
        wait_cycles(2);
        total++; if ({OUT_VALID, OUT_OP1, OUT_OP2, OUT_DEST} !== {1'b1, 32'h7, 32'hA, 5'd5}) $display("FAIL conflict_out got %h/%h/%h/%0d want 1/7/a/5", OUT_VALID, OUT_OP1, OUT_OP2, OUT_DEST); else passed++;
        wait_cycles(1);
    endtask

    task automatic test_backpressure;
        logic stable;
        OUT_READY = 1'b0;
        send_instr(32'h00C03820);
        wait_cycles(2);
        total++; if ({OUT_VALID, OUT_OP1, OUT_OP2} !== {1'b1, 32'h1234, 32'h0}) $display("FAIL bp_out got %h/%h/%h want 1/1234/0", OUT_VALID, OUT_OP1, OUT_OP2); else passed++;
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                WB_ADDR  = 5'd6;
                WB_DATA  = 32'h00005678;
                WB_VALID = 1'b1;
                #1;
                total++; if ({WB_READY, WRITE} !== 2'b11) $display("FAIL bp_wb_in_out got %b want 11", {WB_READY, WRITE}); else passed++;
            end
            @(negedge CLK);
            WB_VALID = 1'b0;
            #1;
            if (!(OUT_VALID === 1'b1 && OUT_OP1 === 32'h1234 && OUT_OP2 === 32'h0 && OUT_DEST === 5'd7 && IN_READY === 1'b0)) stable = 1'b0;
        end
        total++; if (stable !== 1'b1) $display("FAIL bp_stable got %h want 1", stable); else passed++;
        OUT_READY = 1'b1;
        wait_cycles(1);
        send_instr(32'h00C03820);
        wait_cycles(2);
        total++; if (OUT_OP1 !== 32'h5678) $display("FAIL bp_new_value got %h want 00005678", OUT_OP1); else passed++;
        wait_cycles(1);
    endtask

    task automatic test_async_reset;
        logic quiet;
        send_instr(32'h00221820);
        wait_cycles(1);
        #1;
        RST = 1'b1;
        #1;
        total++; if ({OUT_VALID, READ, IN_READY} !== 3'b000) $display("FAIL arst_ctrl got %b want 000", {OUT_VALID, READ, IN_READY}); else passed++;
        total++; if ({OUT_DEST, OUT_FUNCT, OUT_OP1} !== '0) $display("FAIL arst_async got %0d/%h/%h want 0/0/0", OUT_DEST, OUT_FUNCT, OUT_OP1); else passed++;
        @(negedge CLK);
        RST = 1'b0;
        #1;
        total++; if (IN_READY !== 1'b1) $display("FAIL arst_idle got %h want 1", IN_READY); else passed++;
        quiet = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (OUT_VALID !== 1'b0) quiet = 1'b0;
            wait_cycles(1);
        end
        total++; if (quiet !== 1'b1) $display("FAIL arst_no_out got %h want 1", quiet); else passed++;
        send_instr(32'h00221820);
        wait_cycles(2);
        total++; if ({OUT_VALID, OUT_OP1, OUT_OP2, OUT_DEST} !== {1'b1, 32'h7, 32'hA, 5'd3}) $display("FAIL arst_next got %h/%h/%h/%0d want 1/7/a/3", OUT_VALID, OUT_OP1, OUT_OP2, OUT_DEST); else passed++;
        wait_cycles(1);
    endtask

    task automatic test_invariants;
        total++; if (overlap !== 0) $display("FAIL read_write_overlap got %0d want 0", overlap); else passed++;
        total++; if (timeouts !== 0) $display("FAIL handshake_timeouts got %0d want 0", timeouts); else passed++;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'hA5A50000 | i;
        rf[0] = 32'hFFFFFFFF;
        test_reset();
        test_rtype();
        test_itype();
        test_jtype_r0();
        test_conflict();
        test_backpressure();
        test_async_reset();
        test_invariants();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired after %0d of %0d checks", passed, total);
        $fatal(1);
    end

endmodule

// File: doc/operand_fetch_unit.md
# operand_fetch_unit

Decode-side stage directly upstream of `REGISTER_FILE_32x32`. Accepts a 32-bit instruction over a valid/ready handshake, splits it into fields, and drives the register file's READ, ADDR_R1 and ADDR_R2. It captures DATA_R1 and DATA_R2 and presents the ALU operands and destination downstream. It also owns the register file's write port, arbitrating writeback requests against reads because the register file forbids READ and WRITE together.

## Interface
- `DATA_WIDTH`, 32: datapath width (`DATA_WIDTH`).
- `REG_ADDR_WIDTH`, 5: register address width.
- `CLK  in  1`: clock, all state updates on rising edge.
- `RST  in  1`: reset, asynchronous, active-high.
- `IN_INSTR  in  32`: instruction word.
- `IN_VALID  in  1` / `IN_READY  out  1`: instruction handshake.
- `WB_VALID  in  1` / `WB_READY  out  1`: writeback handshake.
- `WB_ADDR  in  5`, `WB_DATA  in  32`: writeback target and value.
- `READ  out  1`, `WRITE  out  1`, `ADDR_R1  out  5`, `ADDR_R2  out  5`, `ADDR_W  out  5`, `DATA_W  out  32`: register file controls.
- `DATA_R1  in  32`, `DATA_R2  in  32`: register file read data.
- `OUT_VALID  out  1` / `OUT_READY  in  1`: operand handshake.
- `OUT_OPCODE  out  6`, `OUT_FUNCT  out  6`, `OUT_SHAMT  out  5`: decoded fields.
- `OUT_OP1  out  32`, `OUT_OP2  out  32`, `OUT_DEST  out  5`: operands and destination register.

## Operation
- Fields: opcode [31:26], rs [25:21], rt [20:16], rd [15:11], shamt [10:6], funct [5:0], imm [15:0], addr [25:0].
- Instruction classes:
  - R-type, opcode 0x00: OP1=R[rs], OP2=R[rt], DEST=rd.
  - J-type, opcode 0x02, 0x03, 0x1b or 0x1c: no register read; OP1=0, OP2=zero-extended addr, DEST=31 for 0x03 (jal), else 0.
  - I-type, all other opcodes: OP1=R[rs], DEST=rt. OP2 is imm zero-extended for opcodes 0x0c and 0x0d; sign-extended otherwise.
- Register 0:
  - Operands read from r0 are forced to 0, regardless of DATA_R*.
  - A writeback to r0 completes its handshake but never asserts WRITE.
- FSM states: IDLE, RD, CAP, OUT.
  - IDLE: on an accepted instruction, latch it. R-type or I-type go to RD; J-type goes straight to OUT with operands formed from the instruction.
  - RD: READ=1, ADDR_R1=rs, ADDR_R2=rt; always goes to CAP.
  - CAP: sample DATA_R1 and DATA_R2 into OUT_OP*; go to OUT.
  - OUT: OUT_VALID=1, all OUT_* stable; go to IDLE when OUT_READY=1.
- Writeback:
  - WB_READY=1 in IDLE and OUT, 0 in RD and CAP.
  - When WB_VALID & WB_READY, WRITE=1 combinationally, with ADDR_W=WB_ADDR and DATA_W=WB_DATA, for that single cycle.
  - READ is never 1 while WRITE is 1.
- IN_READY = (state==IDLE) & !WB_VALID. Writeback wins a simultaneous request; the instruction waits.
- READ and WRITE are 0 in every cycle not listed above.

## Timing
- Reset while RST=1, regardless of the current state:
  - state=IDLE;
  - OUT_VALID, IN_READY, WB_READY, READ and WRITE are 0;
  - OUT_OP1, OUT_OP2, OUT_DEST, OUT_OPCODE, OUT_FUNCT, OUT_SHAMT, ADDR_* and DATA_W are 0.
- Reset mid-operation discards the in-flight instruction. The first cycle after RST falls is IDLE.
- Latency, counted from the accept edge to OUT_VALID high:
  - R-type and I-type: 3 cycles (RD, CAP, then OUT).
  - J-type: 1 cycle.
- Throughput: one instruction per 4 cycles for R/I-type, with no backpressure.
- OUT holds indefinitely under backpressure (OUT_READY=0). IN_READY stays 0 for the whole OUT stay.
- Ordering: a writeback accepted in OUT is committed before the next instruction's RD cycle. That next read therefore sees the new value, so no bypass is needed.
- A writeback request is stalled for at most 2 cycles (RD, CAP).

## Structure
- Shared package (`prj_definition.v`):
  - existing `DATA_WIDTH`, `DATA_INDEX_LIMIT` and `REG_ADDR_INDEX_LIMIT`;
  - new opcode constants `OP_RTYPE`, `OP_JMP`, `OP_JAL`, `OP_PUSH`, `OP_POP`, `OP_ANDI`, `OP_ORI`;
  - FSM state encodings.
- Sub-module: `instr_field_decoder`, purely combinational. Inputs: the instruction. Outputs: the fields, the class (R/I/J), the extended immediate, and DEST.

## Test plan
- Reset/idle: hold RST=1 for 2 cycles, then release → all outputs 0, IN_READY=1 and WB_READY=1 in the next cycle.
- Writeback then R-type:
  - write r1=0x00000005 and r2=0x0000000A;
  - issue 0x00221820 (add r3,r1,r2) → READ=1 with ADDR_R1=1 and ADDR_R2=2 for exactly one cycle;
  - 3 cycles after accept: OUT_OP1=5, OUT_OP2=0xA, OUT_DEST=3, OUT_FUNCT=0x20.
- I-type immediate extension:
  - r1=7, instr 0x2022FFFF (addi r2,r1,-1) → OP2=0xFFFFFFFF, DEST=2;
  - instr 0x3422FFFF (ori) → OP2=0x0000FFFF.
- J-type and r0:
  - instr 0x0C000100 (jal) → OUT_VALID 1 cycle after accept, no READ, OP2=0x100, DEST=31;
  - writeback to r0 with 0xDEADBEEF → WRITE stays 0; a subsequent read of r0 returns 0.
- Conflict and backpressure:
  - IN_VALID and WB_VALID together in IDLE → WRITE that cycle, instruction accepted the next cycle;
  - hold OUT_READY=0 for 5 cycles → OUT_* stable, a writeback is still accepted during OUT, and the next instruction reads the updated value.
- Async reset during CAP → state returns to IDLE without waiting for a CLK edge, OUT_VALID never rises, and the next instruction completes normally.
